mem_stage_access_unit: RTL
==========================

Name: mem_stage_access_unit

Overview:
- Consumer end of the EX/MEM pipeline register. Reads the MEM-stage fields and runs the data-memory access through a req/ack handshake.
- Drives stall back to the upstream pipeline registers while an access is outstanding.
- Registers the retiring instruction's result into the MEM/WB fields for writeback.

Parameters:
- DATA_W, 32, data and address width.
- TO_CYCLES, 255, watchdog limit in cycles; used only with MEM_TIMEOUT_EN.
- TO_W, 8, watchdog counter width; must satisfy TO_CYCLES < 2**TO_W.

Ports:
- clk  in  1  clock, all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- MEM_ALU_OUT  in  DATA_W  effective address, or result for non-memory ops
- MEM_rs2  in  DATA_W  store data
- MEM_rd_ind  in  5  destination register index
- MEM_opcode  in  7  opcode, passed through
- MEM_memread, MEM_memwrite, MEM_regwrite  in  1 each  control bits
- MEM_PC, MEM_INST  in  32 each  PC and instruction, passed through
- dmem_req  out  1  access request
- dmem_we  out  1  1 = store
- dmem_addr  out  DATA_W  word address
- dmem_wdata  out  DATA_W  store data
- dmem_ack  in  1  access complete; dmem_rdata valid when asserted
- dmem_rdata  in  DATA_W  load data
- mem_stall  out  1  freeze upstream pipeline registers
- mem_fault  out  1  one-cycle pulse on misaligned, illegal or timed-out access
- WB_result  out  DATA_W  load data or ALU result
- WB_rd_ind  out  5  destination register index
- WB_regwrite  out  1  register-file write enable
- WB_valid  out  1  a real (non-bubble) instruction retired
- WB_PC, WB_INST  out  32 each  passed through

Behaviour:
- Reset: state=IDLE. dmem_req, dmem_we, dmem_addr, dmem_wdata, mem_fault and all WB_* outputs are 0. Reset has priority over everything. Reset during ACCESS abandons the access; dmem_req is 0 from the next cycle and any late dmem_ack is ignored.
- FSM states: IDLE, ACCESS.
- mem_op = MEM_memread | MEM_memwrite.
- mem_stall is combinational: (IDLE & mem_op & legal) | (ACCESS & !dmem_ack).
- legal = (MEM_ALU_OUT[1:0]==0) & !(MEM_memread & MEM_memwrite).
- IDLE, !mem_op:
  - WB_result = MEM_ALU_OUT; WB_rd_ind, WB_regwrite, WB_PC, WB_INST copied.
  - WB_valid = (MEM_INST != 0). Latency: 1 cycle.
- IDLE, mem_op, !legal:
  - No request issued; mem_fault pulses for 1 cycle.
  - WB_regwrite = 0, WB_valid = 1; instruction retires with no stall.
- IDLE, mem_op, legal:
  - dmem_req = 1 and dmem_we = MEM_memwrite registered on the edge.
  - dmem_addr and dmem_wdata latched from MEM_ALU_OUT and MEM_rs2; go to ACCESS.
  - During this cycle WB_valid = 0 and WB_regwrite = 0 (bubble into WB).
- ACCESS:
  - dmem_req, dmem_we, dmem_addr and dmem_wdata are held stable until dmem_ack.
  - On the edge where dmem_ack = 1: dmem_req drops and state returns to IDLE.
  - At that edge: WB_result = dmem_rdata for a load, else MEM_ALU_OUT. WB_regwrite = MEM_regwrite & MEM_memread (stores never write). WB_valid = 1.
  - Because mem_stall is already low in the ack cycle, upstream advances on the same edge.
- Minimum memory-op latency: 2 cycles (ack in the first ACCESS cycle).
- dmem_ack in IDLE is ignored.
- Back-to-back memory ops: the next op is seen in IDLE on the cycle after ack; no extra bubble beyond the IDLE request cycle.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined: a watchdog counter clears on entry to ACCESS and increments each ACCESS cycle without ack. When it reaches TO_CYCLES:
  - dmem_req drops and state returns to IDLE.
  - mem_fault pulses; WB_regwrite = 0, WB_valid = 1.
  - mem_stall is low in that cycle.
- Undefined: no counter; ACCESS waits indefinitely for dmem_ack.

Decomposition:
- Shared package (pipeline_pkg): FSM state typedef {IDLE, ACCESS}, DATA_W default, opcode constants.
- One natural sub-module, mem_access_watchdog: the counter with clear/enable/expired outputs, instantiated only under MEM_TIMEOUT_EN.

Test Plan:
- Non-memory op: ALU_OUT=0x1234, rd=5, regwrite=1 -> next edge WB_result=0x1234, WB_rd_ind=5, WB_regwrite=1; mem_stall never 1.
- Load, address 0x40, ack 3 cycles after req, rdata=0xDEADBEEF:
  - mem_stall high for 3 cycles.
  - dmem_addr held at 0x40 throughout.
  - WB_result=0xDEADBEEF, WB_regwrite=1.
- Store, address 0x44, rs2=0xA5A5A5A5, ack in the first ACCESS cycle -> dmem_we=1, dmem_wdata=0xA5A5A5A5, WB_regwrite=0, total 2 cycles.
- Misaligned load, address 0x42 -> dmem_req stays 0, mem_fault one-cycle pulse, WB_regwrite=0, no stall.
- rst asserted in the 2nd ACCESS cycle -> next cycle dmem_req=0 and all WB_* = 0; a late ack is ignored.
- MEM_TIMEOUT_EN with TO_CYCLES=4 and ack never asserted -> req drops after 4 ACCESS cycles, mem_fault pulses, pipeline resumes.

Source files
------------

// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared MEM-stage state type, default width and opcode constants
package pipeline_pkg;
    localparam int DATA_W_DEF = 32;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    typedef enum logic {IDLE, ACCESS} state_t;
endpackage

// File: rtl/mem_access_watchdog.sv
// mem_access_watchdog: counts ACCESS cycles without ack and flags expiry on the last allowed cycle
// ports: clk, rst; clear holds the count at zero; enable advances it; expired is high in the
// TO_CYCLES-th consecutive enabled cycle, so the access can be dropped on that edge
module mem_access_watchdog #(
    parameter int TO_CYCLES = 255,
    parameter int TO_W      = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    logic [TO_W-1:0] cnt;
    always_ff @(posedge clk)
        if (rst || clear) cnt <= '0;
        else if (enable) cnt <= cnt + 1'b1;
    assign expired = enable && cnt == TO_W'(TO_CYCLES - 1);
endmodule

// File: rtl/mem_stage_access_unit.sv
// mem_stage_access_unit: MEM stage, runs the data-memory req/ack access and registers MEM/WB fields
// ports: MEM_* EX/MEM register fields in; dmem_* req/ack memory port; mem_stall freezes upstream;
// mem_fault pulses on misaligned/illegal (and, with MEM_TIMEOUT_EN defined, timed-out) accesses;
// WB_* registered writeback fields out
module mem_stage_access_unit
    import pipeline_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int TO_CYCLES = 255,
    parameter int TO_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] MEM_ALU_OUT,
    input  logic [DATA_W-1:0] MEM_rs2,
    input  logic [4:0]        MEM_rd_ind,
    input  logic [6:0]        MEM_opcode,
    input  logic              MEM_memread,
    input  logic              MEM_memwrite,
    input  logic              MEM_regwrite,
    input  logic [31:0]       MEM_PC,
    input  logic [31:0]       MEM_INST,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              mem_stall,
    output logic              mem_fault,
    output logic [DATA_W-1:0] WB_result,
    output logic [4:0]        WB_rd_ind,
    output logic              WB_regwrite,
    output logic              WB_valid,
    output logic [31:0]       WB_PC,
    output logic [31:0]       WB_INST
);
    state_t state;
    logic mem_op, legal, expired, unused_op;
    assign mem_op = MEM_memread || MEM_memwrite;
    assign legal  = MEM_ALU_OUT[1:0] == 2'b00 && !(MEM_memread && MEM_memwrite);
    assign unused_op = (MEM_opcode == OP_LOAD) ^ (MEM_opcode == OP_STORE);
`ifdef MEM_TIMEOUT_EN
    mem_access_watchdog #(.TO_CYCLES(TO_CYCLES), .TO_W(TO_W)) u_wd (
        .clk     (clk),
        .rst     (rst),
        .clear   (state == IDLE),
        .enable  (state == ACCESS && !dmem_ack),
        .expired (expired)
    );
`else
    logic unused_to;
    assign unused_to = TO_CYCLES < (1 << TO_W);
    assign expired = 1'b0;
`endif
    // stall drops in the ack (or expiry) cycle so upstream advances on the same edge
    always_comb mem_stall = state == IDLE ? mem_op && legal : !dmem_ack && !expired;
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            dmem_addr   <= '0;
            dmem_wdata  <= '0;
            mem_fault   <= 1'b0;
            WB_result   <= '0;
            WB_rd_ind   <= '0;
            WB_regwrite <= 1'b0;
            WB_valid    <= 1'b0;
            WB_PC       <= '0;
            WB_INST     <= '0;
        end else begin
            mem_fault <= 1'b0;
            if (state == IDLE) begin
                if (mem_op && legal) begin
                    state       <= ACCESS;
                    dmem_req    <= 1'b1;
                    dmem_we     <= MEM_memwrite;
                    dmem_addr   <= MEM_ALU_OUT;
                    dmem_wdata  <= MEM_rs2;
                    WB_regwrite <= 1'b0;
                    WB_valid    <= 1'b0;
                end else begin
                    // plain ALU op, or an illegal access retiring as a faulted no-write
                    WB_result   <= MEM_ALU_OUT;
                    WB_rd_ind   <= MEM_rd_ind;
                    WB_PC       <= MEM_PC;
                    WB_INST     <= MEM_INST;
                    WB_regwrite <= MEM_regwrite && !mem_op;
                    WB_valid    <= mem_op || MEM_INST != '0;
                    mem_fault   <= mem_op;
                end
            end else if (dmem_ack || expired) begin
                state       <= IDLE;
                dmem_req    <= 1'b0;
                WB_result   <= MEM_memread && dmem_ack ? dmem_rdata : MEM_ALU_OUT;
                WB_rd_ind   <= MEM_rd_ind;
                WB_PC       <= MEM_PC;
                WB_INST     <= MEM_INST;
                WB_regwrite <= dmem_ack && MEM_regwrite && MEM_memread;
                WB_valid    <= 1'b1;
                mem_fault   <= !dmem_ack;
            end else begin
                WB_regwrite <= 1'b0;
                WB_valid    <= 1'b0;
            end
        end
    end
endmodule
